// File: rtl/md_sequencer.sv
// Execute-stage sequencer for a multi-cycle mul/div unit: launches the unit,
// stalls the pipeline while it runs, and issues one writeback (result or exception status).
module md_sequencer #(
    parameter int         TIMEOUT     = 40,
    parameter logic [4:0] RSTATUS_REG = 5'd30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic [4:0]  rd_in,
    input  logic        flush,
    output logic        unit_start,
    output logic        unit_is_div,
    output logic [31:0] unit_opA,
    output logic [31:0] unit_opB,
    input  logic        unit_done,
    input  logic [31:0] unit_result,
    input  logic        unit_exception,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic        r_start;
    logic        r_is_div;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic [4:0]  r_rd;
    logic [31:0] r_result;
    logic        r_exc;

    logic        w_launch;
    logic        w_div0;
    logic        w_run;
    logic        w_done;

    assign w_run    = (r_state == S_RUN);
    assign w_done   = (r_state == S_DONE);
    // A flushed instruction never launches; RUN ignores md_start entirely.
    assign w_launch = md_start & ~flush & ((r_state == S_IDLE) | w_done);
    assign w_div0   = md_is_div & (operandB == 32'd0);

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_launch)    w_next = w_div0 ? S_DONE : S_RUN;
                else if (w_done) w_next = S_IDLE;
            end
            S_RUN: begin
                if (unit_done || r_cnt == CNT_LAST) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, cycle counter and result capture
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_start  <= 1'b0;
            r_is_div <= 1'b0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_rd     <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else begin
            r_start <= w_launch & ~w_div0;
            if (w_launch) begin
                r_opA    <= operandA;
                r_opB    <= operandB;
                r_is_div <= md_is_div;
                r_rd     <= rd_in;
                r_cnt    <= '0;
                r_result <= '0;
                r_exc    <= w_div0;
            end else if (w_run) begin
                if (unit_done) begin
                    r_result <= unit_result;
                    r_exc    <= unit_exception;
                end else if (r_cnt == CNT_LAST) begin
                    r_exc    <= 1'b1;
                end else begin
                    r_cnt    <= r_cnt + 6'd1;
                end
            end
        end
    end

    // Outputs; every exception status code depends only on the op type
    always_comb begin
        unit_start   = r_start;
        unit_is_div  = r_is_div;
        unit_opA     = r_opA;
        unit_opB     = r_opB;
        stall        = w_launch | w_run;
        busy         = w_run | w_done;
        wb_valid     = w_done;
        wb_exception = w_done & r_exc;
        wb_rd        = '0;
        wb_data      = '0;
        if (w_done) begin
            wb_rd   = r_exc ? RSTATUS_REG : r_rd;
            wb_data = r_exc ? (r_is_div ? 32'd5 : 32'd4) : r_result;
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: stimulus pushes expected writebacks,
// a negedge monitor pops and compares each wb_valid.
module tb_md_sequencer;
    localparam int         TO = 40;
    localparam logic [4:0] RS = 5'd30;

    logic        clock = 1'b0;
    logic        reset, md_start, md_is_div, flush, unit_done, unit_exception;
    logic [31:0] operandA, operandB, unit_result;
    logic [4:0]  rd_in;
    logic        unit_start, unit_is_div, stall, busy, wb_valid, wb_exception;
    logic [31:0] unit_opA, unit_opB, wb_data;
    logic [4:0]  wb_rd;

    md_sequencer #(.TIMEOUT(TO), .RSTATUS_REG(RS)) dut (
        .clock(clock), .reset(reset), .md_start(md_start), .md_is_div(md_is_div),
        .operandA(operandA), .operandB(operandB), .rd_in(rd_in), .flush(flush),
        .unit_start(unit_start), .unit_is_div(unit_is_div), .unit_opA(unit_opA),
        .unit_opB(unit_opB), .unit_done(unit_done), .unit_result(unit_result),
        .unit_exception(unit_exception), .stall(stall), .busy(busy),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exception(wb_exception)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
    } wb_t;

    wb_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what one instruction must write back, from the architectural rules
    function automatic wb_t model(input logic [31:0] b, input logic dv, input logic [4:0] rd,
                                  input int k, input logic ex, input logic [31:0] res);
        wb_t w;
        if ((dv && b == 32'd0) || k > TO || ex) begin
            w.rd = RS; w.data = dv ? 32'd5 : 32'd4; w.exc = 1'b1;
        end else begin
            w.rd = rd; w.data = res; w.exc = 1'b0;
        end
        return w;
    endfunction

    // Monitor: every writeback must match the oldest outstanding expectation
    always @(negedge clock) begin : mon
        wb_t e;
        if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL wb_unexpected: got rd=%0d data=%0h, expected no writeback", wb_rd, wb_data);
            end else begin
                e = exp_q.pop_front();
                chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                chk("wb_data", 64'(wb_data), 64'(e.data));
                chk("wb_exception", 64'(wb_exception), 64'(e.exc));
            end
        end else if (reset === 1'b0) begin
            chk("wb_quiet", {27'd0, wb_exception, wb_rd, wb_data}, 64'd0);
        end
    end

    task automatic drive_op(input logic [31:0] a, b, input logic dv, input logic [4:0] rd);
        md_start = 1'b1; flush = 1'b0; operandA = a; operandB = b; md_is_div = dv; rd_in = rd;
    endtask

    // Caller has driven the launch inputs for cycle 0; the unit answers on RUN cycle k.
    // skip=1 means cycle 0 is the previous op's DONE cycle and was already sampled.
    task automatic do_op(input logic [31:0] a, b, input logic dv, input logic [4:0] rd,
                         input int k, input logic ex, input bit skip);
        int          lat, c;
        bit          div0;
        logic [31:0] res;
        div0 = dv && (b == 32'd0);
        res  = dv ? (div0 ? 32'd0 : a / b) : a * b;
        lat  = div0 ? 1 : 1 + ((k < TO) ? k : TO);
        exp_q.push_back(model(b, dv, rd, k, ex, res));
        if (!skip) begin
            @(negedge clock);
            chk("stall_launch", 64'(stall), 64'd1);
            chk("start_c0", 64'(unit_start), 64'd0);
        end
        for (c = 1; c <= lat + 2; c++) begin
            @(posedge clock); #1;
            md_start       = 1'b0;
            unit_done      = !div0 && (c == k);
            unit_result    = unit_done ? res : $urandom;
            unit_exception = unit_done ? ex : 1'($urandom_range(0, 1));
            @(negedge clock);
            if (c < lat) begin
                chk("stall_run", 64'(stall), 64'd1);
                chk("busy_run", 64'(busy), 64'd1);
                chk("unit_start", 64'(unit_start), 64'(c == 1));
                chk("unit_opA", 64'(unit_opA), 64'(a));
                chk("unit_opB", 64'(unit_opB), 64'(b));
                chk("unit_is_div", 64'(unit_is_div), 64'(dv));
            end
            if (wb_valid === 1'b1) break;
        end
        chk("wb_latency", 64'(c), 64'(lat));
        chk("busy_done", 64'(busy), 64'd1);
        chk("stall_done", 64'(stall), 64'd0);
        unit_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        dv, ex;
        logic [4:0]  rd;
        int          k;
        bit          ch;
        reset = 1'b1; md_start = 0; md_is_div = 0; flush = 0; unit_done = 0;
        unit_exception = 0; operandA = 0; operandB = 0; unit_result = 0; rd_in = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_state", {unit_start, busy, stall, wb_valid, unit_is_div, unit_opA[15:0], unit_opB[15:0]}, 64'd0);
        @(posedge clock); #1 reset = 1'b0;

        // 6*7 with the unit answering on RUN cycle 16 -> 17 stall cycles
        @(posedge clock); #1 drive_op(6, 7, 0, 5);  do_op(6, 7, 0, 5, 16, 0, 0);
        // divide by zero: no unit launch, DONE right after
        @(posedge clock); #1 drive_op(9, 0, 1, 3);  do_op(9, 0, 1, 3, 1000, 0, 0);
        // timeouts, div and mul
        @(posedge clock); #1 drive_op(100, 7, 1, 9); do_op(100, 7, 1, 9, 1000, 0, 0);
        @(posedge clock); #1 drive_op(3, 4, 0, 9);  do_op(3, 4, 0, 9, 1000, 0, 0);
        // done on the last allowed cycle, mul overflow, rd 0
        @(posedge clock); #1 drive_op(8, 9, 0, 2);  do_op(8, 9, 0, 2, TO, 0, 0);
        @(posedge clock); #1 drive_op(32'h10000, 32'h10000, 0, 12); do_op(32'h10000, 32'h10000, 0, 12, 5, 1, 0);
        @(posedge clock); #1 drive_op(5, 5, 0, 0);  do_op(5, 5, 0, 0, 3, 0, 0);

        // flushed start never launches
        @(posedge clock); #1 drive_op(1, 2, 0, 6); flush = 1'b1;
        @(negedge clock); chk("flush_stall", 64'(stall), 64'd0);
        @(posedge clock); #1 md_start = 0; flush = 0;
        @(negedge clock); chk("flush_idle", {unit_start, busy}, 64'd0);

        // back-to-back: second op launched from the DONE cycle
        @(posedge clock); #1 drive_op(20, 4, 1, 7); do_op(20, 4, 1, 7, 4, 0, 0);
        drive_op(11, 3, 0, 8); do_op(11, 3, 0, 8, 2, 0, 1);

        // reset in RUN cycle 5 together with unit_done, then a late unit_done
        @(posedge clock); #1 drive_op(2, 3, 0, 4);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clock); #1 md_start = 0;
        end
        reset = 1'b1; unit_done = 1'b1; unit_result = 32'd6;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock); chk("reset_run_idle", {unit_start, busy, stall, wb_valid}, 64'd0);
        @(posedge clock); #1 unit_done = 1'b0;
        @(negedge clock); chk("late_done_idle", {busy, wb_valid}, 64'd0);
        // reset wins over a simultaneous launch
        @(posedge clock); #1 drive_op(4, 4, 0, 1); reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0; md_start = 0;
        @(negedge clock); chk("reset_over_launch", {unit_start, busy}, 64'd0);

        // randomized ops, sometimes chained back-to-back
        ch = 0;
        for (int i = 0; i < 24; i++) begin
            a  = $urandom;
            dv = 1'($urandom_range(0, 1));
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            rd = 5'($urandom);
            k  = ($urandom_range(0, 5) == 0) ? 1000 : int'($urandom_range(1, TO));
            ex = ($urandom_range(0, 4) == 0);
            if (!ch) begin @(posedge clock); #1; end
            drive_op(a, b, dv, rd);
            do_op(a, b, dv, rd, k, ex, ch);
            ch = ($urandom_range(0, 2) == 0);
        end

        repeat (3) @(negedge clock);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
